trap_ctrl: RTL
==============

TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 Parameter: XLEN, 32, data/PC width.
REQ-002 Parameter: CSR_AW, 12, CSR address width.
REQ-003 Port: clk_i  in  1  single clock; all state changes on rising edge.
REQ-004 Port: rst_n_i  in  1  reset, synchronous and active-low.
REQ-005 Port: req_valid_i  in  1  execute-stage instruction valid.
REQ-006 Port: req_ready_o  out  1  high only in IDLE; a request is accepted when req_valid_i & req_ready_o & (is_ecall_i | is_mret_i | illegal_i).
REQ-007 Port: is_ecall_i, is_mret_i, illegal_i  in  1 each  decoded instruction class.
REQ-008 Port: pc_i  in  XLEN  PC of the requesting instruction.
REQ-009 Port: mtvec_i, mepc_i, mstatus_i  in  XLEN each  current CSR values.
REQ-010 Port: irq_i  in  1  external interrupt, level (used only under TRAP_CTRL_IRQ_EN).
REQ-011 Port: csr_we_o  out  1; csr_waddr_o  out  CSR_AW; csr_wdata_o  out  XLEN  CSR write port, one write per cycle, no backpressure.
REQ-012 Port: busy_o  out  1  high whenever state != IDLE (pipeline stall).
REQ-013 Port: redirect_valid_o  out  1; redirect_pc_o  out  XLEN  one-cycle PC redirect plus pipeline flush.

Function
REQ-014 FSM states: IDLE, T_EPC, T_CAUSE, T_STATUS, M_STATUS, REDIRECT.
REQ-015 Priority at accept: irq (if enabled) > illegal_i > is_ecall_i > is_mret_i.
REQ-016 Trap path: IDLE -> T_EPC -> T_CAUSE -> T_STATUS -> REDIRECT -> IDLE; mret path: IDLE -> M_STATUS -> REDIRECT -> IDLE.
REQ-017 At accept, pc_i and cause are latched; later changes on inputs do not affect the sequence.
REQ-018 T_EPC: csr_we_o=1, addr 0x341, data = latched PC with bits [1:0] cleared.
REQ-019 T_CAUSE: csr_we_o=1, addr 0x342, data = 2 (illegal), 11 (ecall), or 0x8000000B (external irq).
REQ-020 T_STATUS: csr_we_o=1, addr 0x300, data = mstatus_i with MPIE(bit7)=MIE(bit3), MIE=0, MPP[12:11]=2'b11.
REQ-021 M_STATUS: csr_we_o=1, addr 0x300, data = mstatus_i with MIE=MPIE, MPIE=1, MPP=2'b11.
REQ-022 REDIRECT: redirect_valid_o=1 for exactly one cycle; pc = {mtvec_i[XLEN-1:2],2'b00} on the trap path, mepc_i on the mret path (sampled in REDIRECT).
REQ-023 Trap latency: accept cycle N, CSR writes N+1..N+3, redirect N+4, req_ready_o high again N+5; mret: write N+1, redirect N+2, ready N+3.
REQ-024 Outside the write states csr_we_o=0, and csr_waddr_o/csr_wdata_o are 0.
REQ-025 req_valid_i with no trap class set is ignored (stays IDLE, req_ready_o stays 1).
REQ-026 Requests while busy are not accepted or queued; the stalled pipeline holds them.

Reset
REQ-027 rst_n_i low at any clock edge forces IDLE and clears latched PC/cause, including mid-sequence; remaining CSR writes and the redirect are abandoned.
REQ-028 During and after reset: req_ready_o=1, busy_o=0, csr_we_o=0, redirect_valid_o=0, all data outputs 0.

Configuration
REQ-029 Macro TRAP_CTRL_IRQ_EN defined: in IDLE, irq_i & mstatus_i[3] starts the trap path with cause 0x8000000B and latched PC = pc_i when req_valid_i else mepc_i. This takes priority over any simultaneous request, which is not accepted.
REQ-030 Macro undefined: irq_i is ignored, and no interrupt cause is ever written.

Structure
REQ-031 The shared package holds the state enumeration, CSR addresses (0x300/0x341/0x342), mcause codes, and mstatus bit positions (MIE=3, MPIE=7, MPP=12:11).
REQ-032 The block is a single module with no sub-module; the mstatus update is a local function.

Verification
REQ-033 ecall at pc_i=0x0000_0104, mtvec_i=0x0000_0803: writes 0x341<=0x104, 0x342<=11, 0x300<=updated; redirect to 0x800 on cycle N+4.
REQ-034 mret with mepc_i=0x0000_0200, mstatus_i=0x80 (MPIE=1): write 0x300<=0x1888 (MIE=1, MPIE=1, MPP=11); redirect 0x200 on cycle N+2.
REQ-035 illegal_i and is_ecall_i asserted together: mcause written as 2.
REQ-036 rst_n_i low during T_CAUSE: no 0x342/0x300 write and no redirect; IDLE next cycle with all outputs 0.
REQ-037 New ecall held valid during the sequence: accepted only on cycle N+5, yielding a second full sequence.
REQ-038 With TRAP_CTRL_IRQ_EN, irq_i=1, mstatus_i=0x8, concurrent ecall: mcause=0x8000000B and the ecall is not accepted; without the macro the ecall is taken with mcause 11.

Source files
------------

// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the machine-mode trap controller: FSM states, latched trap
// causes, CSR addresses, mcause codes and mstatus bit positions.
package trap_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StTEpc,
    StTCause,
    StTStatus,
    StMStatus,
    StRedirect
  } state_e;

  // CauseNone marks the mret path; the others select the mcause value.
  typedef enum logic [1:0] {
    CauseNone,
    CauseIllegal,
    CauseEcall,
    CauseIrq
  } cause_e;

  localparam logic [11:0] CsrMstatus = 12'h300;
  localparam logic [11:0] CsrMepc    = 12'h341;
  localparam logic [11:0] CsrMcause  = 12'h342;

  // Exception codes; the interrupt code is combined with the MSB interrupt flag.
  localparam int unsigned McauseIllegal = 2;
  localparam int unsigned McauseEcall   = 11;
  localparam int unsigned McauseExtIrq  = 11;

  localparam int unsigned MstatusMie   = 3;
  localparam int unsigned MstatusMpie  = 7;
  localparam int unsigned MstatusMppLo = 11;
  localparam int unsigned MstatusMppHi = 12;

endpackage

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: sequences the mepc/mcause/mstatus CSR writes for ecall,
// illegal instruction and (optionally) external interrupt, the mstatus restore for mret,
// then issues a one-cycle PC redirect. Define TRAP_CTRL_IRQ_EN to enable the interrupt path.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CSR_AW = 12
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              is_ecall_i,
  input  logic              is_mret_i,
  input  logic              illegal_i,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [XLEN-1:0]   mtvec_i,
  input  logic [XLEN-1:0]   mepc_i,
  input  logic [XLEN-1:0]   mstatus_i,
  input  logic              irq_i,
  output logic              csr_we_o,
  output logic [CSR_AW-1:0] csr_waddr_o,
  output logic [XLEN-1:0]   csr_wdata_o,
  output logic              busy_o,
  output logic              redirect_valid_o,
  output logic [XLEN-1:0]   redirect_pc_o
);

  state_e            state_q;
  cause_e            cause_q;
  logic [XLEN-1:0]   pc_q;
  logic              irq_take;
  logic              unused_in;

  // Trap entry stacks MIE into MPIE and disables; mret restores MIE and sets MPIE.
  // MPP is always forced to machine mode.
  function automatic logic [XLEN-1:0] mstatus_update(input logic [XLEN-1:0] s,
                                                     input logic            is_mret);
    logic [XLEN-1:0] r;
    r = s;
    if (is_mret) begin
      r[MstatusMie]  = s[MstatusMpie];
      r[MstatusMpie] = 1'b1;
    end else begin
      r[MstatusMpie] = s[MstatusMie];
      r[MstatusMie]  = 1'b0;
    end
    r[MstatusMppHi:MstatusMppLo] = 2'b11;
    return r;
  endfunction

`ifdef TRAP_CTRL_IRQ_EN
  assign irq_take  = irq_i & mstatus_i[MstatusMie];
  assign unused_in = ^{pc_i[1:0], mtvec_i[1:0]};
`else
  assign irq_take  = 1'b0;
  assign unused_in = ^{pc_i[1:0], mtvec_i[1:0], irq_i};
`endif

  // Sequencer: accept in idle, latch PC (word-aligned) and cause, then step through writes.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
      cause_q <= CauseNone;
      pc_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (irq_take) begin
            state_q <= StTEpc;
            cause_q <= CauseIrq;
            pc_q    <= req_valid_i ? {pc_i[XLEN-1:2], 2'b00} : {mepc_i[XLEN-1:2], 2'b00};
          end else if (req_valid_i && (illegal_i || is_ecall_i)) begin
            state_q <= StTEpc;
            cause_q <= illegal_i ? CauseIllegal : CauseEcall;
            pc_q    <= {pc_i[XLEN-1:2], 2'b00};
          end else if (req_valid_i && is_mret_i) begin
            state_q <= StMStatus;
            cause_q <= CauseNone;
          end
        end
        StTEpc:     state_q <= StTCause;
        StTCause:   state_q <= StTStatus;
        StTStatus:  state_q <= StRedirect;
        StMStatus:  state_q <= StRedirect;
        StRedirect: state_q <= StIdle;
        default:    state_q <= StIdle;
      endcase
    end
  end

  // Outputs decode from state; forced to idle values while reset is asserted so nothing
  // leaks out during the reset cycle itself.
  always_comb begin
    req_ready_o      = 1'b0;
    busy_o           = 1'b1;
    csr_we_o         = 1'b0;
    csr_waddr_o      = '0;
    csr_wdata_o      = '0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = '0;
    if (!rst_n_i) begin
      req_ready_o = 1'b1;
      busy_o      = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          req_ready_o = 1'b1;
          busy_o      = 1'b0;
        end
        StTEpc: begin
          csr_we_o    = 1'b1;
          csr_waddr_o = CSR_AW'(CsrMepc);
          csr_wdata_o = pc_q;
        end
        StTCause: begin
          csr_we_o    = 1'b1;
          csr_waddr_o = CSR_AW'(CsrMcause);
          unique case (cause_q)
            CauseIllegal: csr_wdata_o = XLEN'(McauseIllegal);
            CauseIrq:     csr_wdata_o = {1'b1, (XLEN-1)'(McauseExtIrq)};
            default:      csr_wdata_o = XLEN'(McauseEcall);
          endcase
        end
        StTStatus: begin
          csr_we_o    = 1'b1;
          csr_waddr_o = CSR_AW'(CsrMstatus);
          csr_wdata_o = mstatus_update(mstatus_i, 1'b0);
        end
        StMStatus: begin
          csr_we_o    = 1'b1;
          csr_waddr_o = CSR_AW'(CsrMstatus);
          csr_wdata_o = mstatus_update(mstatus_i, 1'b1);
        end
        StRedirect: begin
          redirect_valid_o = 1'b1;
          redirect_pc_o    = (cause_q == CauseNone) ? mepc_i : {mtvec_i[XLEN-1:2], 2'b00};
        end
        default: ;
      endcase
    end
  end

endmodule
